gshare_predictor: RTL
=====================

// Module: gshare_predictor
// PURPOSE
//  Global-history (gshare) direction predictor; replaces the single 2-bit branch_predictor in the CPU top.
//  Looked up combinationally in ID with the branch PC.
//  predict_o is ANDed with the Control branch flag to form predict_taken.
//  Updated from EX when the branch resolves. Also keeps branch and mispredict event counters.
// PARAMETERS
//  INDEX_BITS  6      log2 of pattern-table entries (64 x 2-bit counters)
//  GHR_BITS    6      global history length; must satisfy 1 <= GHR_BITS <= INDEX_BITS
//  CTR_INIT    2'b11  counter reset value (strongly taken)
//  CNT_BITS    16     width of each performance counter
// PORTS
//  clk_i            in   1           clock, all state updates on rising edge
//  rst_i            in   1           asynchronous, active-low reset
//  lookup_pc_i      in   32          PC of the instruction in ID (IDPC)
//  lookup_valid_i   in   1           ID instruction is a branch
//  predict_o        out  1           1 = predict taken; 0 when lookup_valid_i=0
//  lookup_idx_o     out  INDEX_BITS  table index used; travels down ID/EX with the branch
//  update_i         in   1           branch resolving in EX this cycle (EXbranch)
//  update_idx_i     in   INDEX_BITS  lookup_idx_o value carried from ID/EX
//  result_i         in   1           actual outcome, 1 = taken (isZero for beq)
//  predicted_i      in   1           prediction made for this branch (EX_predict_taken)
//  ghr_o            out  GHR_BITS    current global history, for debug
//  branch_cnt_o     out  CNT_BITS    resolved branches since reset
//  mispredict_cnt_o out  CNT_BITS    resolved branches with predicted_i != result_i
// BEHAVIOUR
//  Reset (rst_i=0, asynchronous):
//   - all counters set to CTR_INIT; GHR set to 0; branch_cnt_o and mispredict_cnt_o set to 0.
//   - predict_o and lookup_idx_o are combinational, so they follow the reset state immediately.
//   - Reset mid-update discards that update entirely.
//  Lookup (combinational, zero latency):
//   - idx = lookup_pc_i[INDEX_BITS+1:2] ^ {zero-extend GHR}.
//   - predict_o = lookup_valid_i & table[idx][1].
//   - lookup_idx_o = idx regardless of lookup_valid_i.
//  Update (rising edge, when update_i=1):
//   - table[update_idx_i] saturates: taken -> min(ctr+1, 3); not taken -> max(ctr-1, 0).
//   - GHR <= {GHR[GHR_BITS-2:0], result_i}. For GHR_BITS=1: GHR <= result_i.
//   - branch_cnt_o increments; mispredict_cnt_o increments when predicted_i != result_i.
//   - Both counters saturate at all-ones; they never wrap.
//   - update_i=0: no state changes.
//  History is non-speculative: the pipeline has at most one unresolved branch (ID) while one resolves (EX).
//  Same cycle lookup and update:
//   - lookup uses pre-edge GHR and table contents; no bypass.
//   - This holds even when idx equals update_idx_i.
//   - The new values are visible from the next cycle.
//  ID stall: lookup_pc_i is held, so the output is stable; no internal stall input.
//  Flush: the caller qualifies update_i. A flushed EX slot must present update_i=0.
//  Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
// STRUCTURE
//  Shared include bp_defs.vh holds:
//   - counter encoding localparams (BP_SNT/BP_WNT/BP_WT/BP_ST)
//   - function bp_sat_next(ctr, taken)
//  Sub-module bp_perf_counters: two saturating CNT_BITS counters with a common enable.
//  Pattern table: reg array [0:2**INDEX_BITS-1] of 2 bits, asynchronous read, one write port.
// TESTING
//  1. Reset, lookup_valid_i=1, pc=0x10 -> idx=4, predict_o=1; ghr_o=0, both counters 0.
//  2. Four updates at idx 4 with result_i=0 -> counter goes 11,10,01,00,00 (saturates).
//     With ghr_o forced to 0 again by reset-free history 0s, lookup pc=0x10 gives predict_o=0.
//  3. Update result_i=1 x3 from reset -> ghr_o=6'b000111. pc=0x10 now gives idx=4^7=3.
//  4. Same-cycle lookup and update at idx 4 (ctr 11 -> 10 then 01):
//     - predict_o shows pre-edge bit 1 in the update cycle.
//     - Next cycle it shows the updated value.
//  5. Set CNT_BITS=4 and issue 20 updates with predicted_i != result_i:
//     - both counters stop at 15; no wrap.
//  6. Assert rst_i low asynchronously between clock edges while update_i=1:
//     - counters, GHR and table return to their reset values at once.
//     - The pending update is not applied.

Source files
------------

// File: rtl/gshare_predictor_pkg.sv
// rtl/gshare_predictor_pkg.sv - counter encoding and saturating update helper for the gshare predictor
package gshare_predictor_pkg;

  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

  function automatic logic [1:0] bp_sat_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == BP_ST) ? BP_ST : ctr + 2'd1;
    end
    return (ctr == BP_SNT) ? BP_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/gshare_predictor_perf_counters.sv
// rtl/gshare_predictor_perf_counters.sv - saturating branch and mispredict event counters
module gshare_predictor_perf_counters #(
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                miss_i,
  output logic [CNT_BITS-1:0] branch_cnt_o,
  output logic [CNT_BITS-1:0] mispredict_cnt_o
);

  logic [CNT_BITS-1:0] branch_q, branch_d;
  logic [CNT_BITS-1:0] miss_q, miss_d;

  // Counters hold at all-ones so long runs never read back as small numbers.
  always_comb begin
    branch_d = branch_q;
    miss_d   = miss_q;
    if (en_i) begin
      if (branch_q != '1) branch_d = branch_q + CNT_BITS'(1);
      if (miss_i && (miss_q != '1)) miss_d = miss_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      branch_q <= '0;
      miss_q   <= '0;
    end else begin
      branch_q <= branch_d;
      miss_q   <= miss_d;
    end
  end

  assign branch_cnt_o     = branch_q;
  assign mispredict_cnt_o = miss_q;

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare direction predictor: PC^history indexed 2-bit counter table
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned GHR_BITS   = 6,
  parameter logic [1:0]  CTR_INIT   = BP_ST,
  parameter int unsigned CNT_BITS   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           lookup_pc_i,
  input  logic                  lookup_valid_i,
  output logic                  predict_o,
  output logic [INDEX_BITS-1:0] lookup_idx_o,
  input  logic                  update_i,
  input  logic [INDEX_BITS-1:0] update_idx_i,
  input  logic                  result_i,
  input  logic                  predicted_i,
  output logic [GHR_BITS-1:0]   ghr_o,
  output logic [CNT_BITS-1:0]   branch_cnt_o,
  output logic [CNT_BITS-1:0]   mispredict_cnt_o
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            pht_q [ENTRIES];
  logic [1:0]            pht_wr_d;
  logic [GHR_BITS-1:0]   ghr_q, ghr_d;
  logic [INDEX_BITS-1:0] idx;
  logic                  unused_pc;

  assign unused_pc = ^{lookup_pc_i[31:INDEX_BITS+2], lookup_pc_i[1:0]};

  // Lookup reads pre-edge state only; a same-cycle update becomes visible next cycle.
  assign idx          = lookup_pc_i[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
  assign lookup_idx_o = idx;
  assign predict_o    = lookup_valid_i & pht_q[idx][1];
  assign ghr_o        = ghr_q;

  assign pht_wr_d = bp_sat_next(pht_q[update_idx_i], result_i);

  generate
    if (GHR_BITS == 1) begin : g_ghr1
      assign ghr_d = result_i;
    end else begin : g_ghrn
      assign ghr_d = {ghr_q[GHR_BITS-2:0], result_i};
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ghr_q <= '0;
    end else if (update_i) begin
      ghr_q <= ghr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= CTR_INIT;
    end else if (update_i) begin
      pht_q[update_idx_i] <= pht_wr_d;
    end
  end

  gshare_predictor_perf_counters #(
    .CNT_BITS(CNT_BITS)
  ) u_perf (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .en_i            (update_i),
    .miss_i          (predicted_i ^ result_i),
    .branch_cnt_o    (branch_cnt_o),
    .mispredict_cnt_o(mispredict_cnt_o)
  );

endmodule
